sort4_ctrl: RTL

SORT4_CTRL -- requirements
Module: sort4_ctrl

---
 rtl/sort4_pkg.sv | 17 +
 rtl/sort4_ctrl_if.sv | 23 ++
 rtl/cmp4b.sv | 14 +
 rtl/sort4_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sort4_pkg.sv
// Shared types and constants for the four-element bubble sorter.
package sort4_pkg;

   localparam int N_ELEM   = 4;
   localparam int ELEM_W   = 4;
   localparam int MAX_PASS = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Element k sits at bits [4k+3:4k], matching the din/dout packing.
   typedef logic [N_ELEM-1:0][ELEM_W-1:0] elems_t;

endpackage

// File: rtl/sort4_ctrl_if.sv
// Request/result bundle between a sort requester (master) and sort4_ctrl (slave).
interface sort4_ctrl_if;
   import sort4_pkg::*;

   logic       start;
   logic       order;
   elems_t     din;
   logic       busy;
   logic       done;
   elems_t     dout;
   logic [2:0] swaps;

   modport master (
      output start, order, din,
      input  busy, done, dout, swaps
   );

   modport slave (
      input  start, order, din,
      output busy, done, dout, swaps
   );

endinterface

// File: rtl/cmp4b.sv
// Unsigned 4-bit magnitude comparator.
module cmp4b (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic       eq,
   output logic       lt,
   output logic       gt
);

   assign eq = (x == y);
   assign lt = (x < y);
   assign gt = (x > y);

endmodule

// File: rtl/sort4_ctrl.sv
// Sequential bubble sort of four 4-bit elements, one compare per cycle
// through a single shared comparator; optional early exit on a swap-free pass.
module sort4_ctrl
   import sort4_pkg::*;
#(
   parameter int unsigned EARLY_EXIT = 1
) (
   input logic         clk,
   input logic         rst_b,
   sort4_ctrl_if.slave bus
);

   state_t            state_q;
   elems_t            elem_q;
   elems_t            elem_d;
   elems_t            dout_q;
   logic              order_q;
   logic [1:0]        j_q;
   logic [1:0]        pass_q;
   logic [2:0]        swapCnt_q;
   logic [2:0]        swapCnt_d;
   logic [2:0]        swaps_q;
   logic              passSwap_q;
   logic              passSwap_d;
   logic              busy_q;
   logic              done_q;

   logic [ELEM_W-1:0] opA;
   logic [ELEM_W-1:0] opB;
   logic              cmpEq;
   logic              cmpLt;
   logic              cmpGt;
   logic              doSwap;
   logic              passEnd;
   logic              finish;

   always_comb begin
      opA = elem_q[0];
      opB = elem_q[1];
      case (j_q)
         2'd1: begin
            opA = elem_q[1];
            opB = elem_q[2];
         end
         2'd2: begin
            opA = elem_q[2];
            opB = elem_q[3];
         end
         default: ;
      endcase
   end

   cmp4b uCmp (
      .x  (opA),
      .y  (opB),
      .eq (cmpEq),
      .lt (cmpLt),
      .gt (cmpGt)
   );

   // Equal operands never swap, which keeps the sort stable.
   always_comb begin
      doSwap = (state_q == CMP) && !cmpEq && (order_q ? cmpLt : cmpGt);
      elem_d = elem_q;
      if (doSwap) begin
         elem_d[j_q]        = opB;
         elem_d[j_q + 2'd1] = opA;
      end
      swapCnt_d  = swapCnt_q + {2'b00, doSwap};
      passSwap_d = passSwap_q | doSwap;
      passEnd    = (j_q == 2'd2);
      finish     = passEnd &&
                   ((pass_q == 2'(MAX_PASS - 1)) || ((EARLY_EXIT != 0) && !passSwap_d));
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= IDLE;
         elem_q     <= '0;
         dout_q     <= '0;
         order_q    <= 1'b0;
         j_q        <= 2'd0;
         pass_q     <= 2'd0;
         swapCnt_q  <= 3'd0;
         swaps_q    <= 3'd0;
         passSwap_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  elem_q     <= bus.din;
                  order_q    <= bus.order;
                  j_q        <= 2'd0;
                  pass_q     <= 2'd0;
                  swapCnt_q  <= 3'd0;
                  passSwap_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= CMP;
               end
            end
            CMP: begin
               elem_q    <= elem_d;
               swapCnt_q <= swapCnt_d;
               if (!passEnd) begin
                  j_q        <= j_q + 2'd1;
                  passSwap_q <= passSwap_d;
               end else if (finish) begin
                  // Result is taken from the next-state values so a swap on this edge is included.
                  passSwap_q <= passSwap_d;
                  dout_q     <= elem_d;
                  swaps_q    <= swapCnt_d;
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  pass_q     <= pass_q + 2'd1;
                  j_q        <= 2'd0;
                  passSwap_q <= 1'b0;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.dout  = dout_q;
   assign bus.swaps = swaps_q;

endmodule
